// File: rtl/proj_io_pkg.sv
// Shared board-I/O types and constants for the SW/KEY conditioning slice.
// No logic: key channel state encoding, board constants, counter width helper.
// No flow control.
package proj_io_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        HELD      = 2'd2,
        REL_CHK   = 2'd3
    } key_state_t;

    localparam int CLK_HZ = 50_000_000;
    localparam int NKEYS  = 2;
    localparam int NSW    = 10;

    // Bits needed to hold the largest of the three cycle counts.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One push-button channel: 2-flop sync, debounce FSM, press/release strobes (auto-repeat with KEY_REPEAT_EN).
// Latency: pad edge -> strobe = 2 sync + DEBOUNCE_CYCLES + 1 output register cycles.
// No backpressure: strobes are single-cycle and are never held or stalled.
module key_debounce_ch
    import proj_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic level,
    output logic press,
    output logic rel
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic            s1, s2, k;
    key_state_t      state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            press_nxt, rel_nxt, rep_nxt;

    // Sync flops rest at the released pad level so reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= key_n;
            s2 <= s1;
        end
    end

    assign k = ~s2;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        press_nxt = 1'b0;
        rel_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (k) begin
                    state_nxt = PRESS_CHK;
                    cnt_nxt   = '0;
                end
            end
            PRESS_CHK: begin
                if (!k) begin
                    state_nxt = IDLE;
                end else if (cnt == DB_LAST) begin
                    state_nxt = HELD;
                    press_nxt = 1'b1;
                end else begin
                    cnt_nxt = sat_inc(cnt);
                end
            end
            HELD: begin
                if (!k) begin
                    state_nxt = REL_CHK;
                    cnt_nxt   = '0;
                end
            end
            REL_CHK: begin
                if (k) begin
                    state_nxt = HELD;
                end else if (cnt == DB_LAST) begin
                    state_nxt = IDLE;
                    rel_nxt   = 1'b1;
                end else begin
                    cnt_nxt = sat_inc(cnt);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

`ifdef KEY_REPEAT_EN
    localparam logic [CW-1:0] RD_LAST   = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RD_RELOAD = CW'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [CW-1:0] rcnt, rcnt_nxt;

    // Reloading to DELAY-PERIOD makes later strobes land PERIOD cycles apart.
    always_comb begin
        rcnt_nxt = rcnt;
        rep_nxt  = 1'b0;
        case (state)
            HELD: begin
                if (k) begin
                    if (rcnt == RD_LAST) begin
                        rep_nxt  = 1'b1;
                        rcnt_nxt = RD_RELOAD;
                    end else begin
                        rcnt_nxt = sat_inc(rcnt);
                    end
                end
            end
            REL_CHK: rcnt_nxt = rcnt;
            default: rcnt_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rcnt <= '0;
        else        rcnt <= rcnt_nxt;
    end
`else
    assign rep_nxt = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            level <= (state_nxt == HELD) || (state_nxt == REL_CHK);
            press <= press_nxt | rep_nxt;
            rel   <= rel_nxt;
        end
    end

endmodule

// File: rtl/key_sw_conditioner.sv
// Board input conditioner: synchronised switches with change strobe, debounced keys; optional KEY_REPEAT_EN auto-repeat.
// Latency: SW 2 cycles to SW_SYNC; KEY edge -> strobe 2 + DEBOUNCE_CYCLES + 1 cycles.
// No backpressure: all strobes are single-cycle, downstream must sample them when they fire.
module key_sw_conditioner
    import proj_io_pkg::*;
#(
    parameter int NKEYS           = proj_io_pkg::NKEYS,
    parameter int NSW             = proj_io_pkg::NSW,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [NKEYS-1:0] KEY,
    input  logic [NSW-1:0]   SW,
    output logic [NKEYS-1:0] KEY_LEVEL,
    output logic [NKEYS-1:0] KEY_PRESS,
    output logic [NKEYS-1:0] KEY_RELEASE,
    output logic [NSW-1:0]   SW_SYNC,
    output logic             SW_CHG
);

    logic [NSW-1:0] sw_s1, sw_prev;
    logic [2:0]     arm;

    // arm[2] rises once sw_prev holds real synchronised pad data, so static switches never strobe.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sw_s1   <= '0;
            SW_SYNC <= '0;
            sw_prev <= '0;
            arm     <= '0;
        end else begin
            sw_s1   <= SW;
            SW_SYNC <= sw_s1;
            sw_prev <= SW_SYNC;
            arm     <= {arm[1:0], 1'b1};
        end
    end

    assign SW_CHG = arm[2] & (|(SW_SYNC ^ sw_prev));

    for (genvar i = 0; i < NKEYS; i++) begin : g_key
        key_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clk   (CLK),
            .rst_n (RST_N),
            .key_n (KEY[i]),
            .level (KEY_LEVEL[i]),
            .press (KEY_PRESS[i]),
            .rel   (KEY_RELEASE[i])
        );
    end

endmodule
